// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline-control definitions: opcode[6:2] constants, ALUOp classes
// and the per-instruction control bundle carried from ID into EX.
package rv32_pkg;

  localparam int unsigned OPC_W       = 5;
  localparam int unsigned ALUOP_MIN_W = 2;
  localparam int unsigned INST_RD_W   = 5;

  localparam logic [OPC_W-1:0] OPC_OP     = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STORE  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 5'b11000;
  localparam logic [OPC_W-1:0] OPC_JAL    = 5'b11011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 5'b11001;
  localparam logic [OPC_W-1:0] OPC_LUI    = 5'b01101;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 5'b00101;

  localparam logic [ALUOP_MIN_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_MIN_W-1:0] ALUOP_BR    = 2'b01;
  localparam logic [ALUOP_MIN_W-1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [ALUOP_MIN_W-1:0] ALUOP_PASSB = 2'b11;

  typedef struct packed {
    logic                   branch;
    logic                   jump;
    logic                   jalr;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   alu_src;
    logic                   reg_write;
    logic [ALUOP_MIN_W-1:0] alu_op;
  } ctrl_bundle;

  localparam ctrl_bundle CTRL_BUBBLE = '0;

endpackage

// File: rtl/rv32_main_decode.sv
// Combinational RV32I main decoder: instruction word to control bundle,
// destination register, register-operand usage and illegal flag.
module rv32_main_decode
  import rv32_pkg::*;
(
  input  logic [31:0]          i_inst,
  output ctrl_bundle           o_ctrl,
  output logic [INST_RD_W-1:0] o_rd,
  output logic                 o_uses_rs1,
  output logic                 o_uses_rs2,
  output logic                 o_illegal
);

  logic                 w_has_rd;
  logic [INST_RD_W-1:0] w_inst_rd;
  logic                 w_unused_hi;

  assign w_inst_rd   = i_inst[11:7];
  // Operand fields are compared in the top; funct/imm bits do not affect control.
  assign w_unused_hi = ^i_inst[31:12];

  always_comb begin
    o_ctrl     = CTRL_BUBBLE;
    o_uses_rs1 = 1'b0;
    o_uses_rs2 = 1'b0;
    o_illegal  = 1'b0;
    w_has_rd   = 1'b1;
    if (i_inst[1:0] != 2'b11) begin
      o_illegal = 1'b1;
    end else begin
      case (i_inst[6:2])
        OPC_OP: begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_FUNCT;
          o_uses_rs1       = 1'b1;
          o_uses_rs2       = 1'b1;
        end
        OPC_OPIMM: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_FUNCT;
          o_uses_rs1       = 1'b1;
        end
        OPC_LOAD: begin
          o_ctrl.mem_read   = 1'b1;
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.alu_src    = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.alu_op     = ALUOP_ADD;
          o_uses_rs1        = 1'b1;
        end
        OPC_STORE: begin
          o_ctrl.mem_write = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_uses_rs1       = 1'b1;
          o_uses_rs2       = 1'b1;
          w_has_rd         = 1'b0;
        end
        OPC_BRANCH: begin
          o_ctrl.branch = 1'b1;
          o_ctrl.alu_op = ALUOP_BR;
          o_uses_rs1    = 1'b1;
          o_uses_rs2    = 1'b1;
          w_has_rd      = 1'b0;
        end
        OPC_JAL: begin
          o_ctrl.jump      = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        OPC_JALR: begin
          o_ctrl.jalr      = 1'b1;
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_ADD;
          o_uses_rs1       = 1'b1;
        end
        OPC_LUI: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_PASSB;
        end
        OPC_AUIPC: begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.reg_write = 1'b1;
          o_ctrl.alu_op    = ALUOP_ADD;
        end
        default: o_illegal = 1'b1;
      endcase
    end
    if (o_illegal) begin
      w_has_rd = 1'b0;
    end
    // Writes to x0 are architecturally discarded, so never request them.
    if (w_inst_rd == '0) begin
      o_ctrl.reg_write = 1'b0;
    end
    o_rd = w_has_rd ? w_inst_rd : '0;
  end

endmodule

// File: rtl/rv32_pipe_ctrl.sv
// Pipelined RV32I control: ID decode, load-use stall, taken-branch flush and the
// ID/EX, EX/MEM, MEM/WB control registers.
module rv32_pipe_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter bit          HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           id_inst,
  input  logic                  id_valid,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_jalr,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_reg_write,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_illegal,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  mem_reg_write,
  output logic                  mem_link,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic                  wb_link,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  ctrl_bundle           w_dec_ctrl;
  logic [INST_RD_W-1:0] w_dec_rd;
  logic                 w_uses_rs1;
  logic                 w_uses_rs2;
  logic                 w_dec_illegal;
  logic [REG_ADDR_W-1:0] w_rs1;
  logic [REG_ADDR_W-1:0] w_rs2;
  logic                 w_load_use;
  logic                 w_bubble;

  ctrl_bundle            r_ex;
  logic [REG_ADDR_W-1:0] r_ex_rd;
  logic                  r_ex_illegal;
  logic                  r_mem_mem_read;
  logic                  r_mem_mem_write;
  logic                  r_mem_mem_to_reg;
  logic                  r_mem_reg_write;
  logic                  r_mem_link;
  logic [REG_ADDR_W-1:0] r_mem_rd;
  logic                  r_wb_reg_write;
  logic                  r_wb_mem_to_reg;
  logic                  r_wb_link;
  logic [REG_ADDR_W-1:0] r_wb_rd;

  rv32_main_decode u_dec (
    .i_inst     (id_inst),
    .o_ctrl     (w_dec_ctrl),
    .o_rd       (w_dec_rd),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_illegal  (w_dec_illegal)
  );

  assign w_rs1 = REG_ADDR_W'(id_inst[19:15]);
  assign w_rs2 = REG_ADDR_W'(id_inst[24:20]);

  // Load in EX whose result a consumer in ID needs before it leaves MEM.
  assign w_load_use = HAZARD_EN && id_valid && r_ex.mem_read && (r_ex_rd != '0) &&
                      ((w_uses_rs1 && (r_ex_rd == w_rs1)) ||
                       (w_uses_rs2 && (r_ex_rd == w_rs2)));

  assign w_bubble = ex_branch_taken || w_load_use || !id_valid;

  // Flush beats stall: the instruction in ID is on the wrong path anyway.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush = 1'b1;
    end else if (w_load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex             <= CTRL_BUBBLE;
      r_ex_rd          <= '0;
      r_ex_illegal     <= 1'b0;
      r_mem_mem_read   <= 1'b0;
      r_mem_mem_write  <= 1'b0;
      r_mem_mem_to_reg <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_link       <= 1'b0;
      r_mem_rd         <= '0;
      r_wb_reg_write   <= 1'b0;
      r_wb_mem_to_reg  <= 1'b0;
      r_wb_link        <= 1'b0;
      r_wb_rd          <= '0;
    end else begin
      if (w_bubble) begin
        r_ex         <= CTRL_BUBBLE;
        r_ex_rd      <= '0;
        r_ex_illegal <= 1'b0;
      end else begin
        r_ex         <= w_dec_ctrl;
        r_ex_rd      <= REG_ADDR_W'(w_dec_rd);
        r_ex_illegal <= w_dec_illegal;
      end
      r_mem_mem_read   <= r_ex.mem_read;
      r_mem_mem_write  <= r_ex.mem_write;
      r_mem_mem_to_reg <= r_ex.mem_to_reg;
      r_mem_reg_write  <= r_ex.reg_write;
      r_mem_link       <= r_ex.jump | r_ex.jalr;
      r_mem_rd         <= r_ex_rd;
      r_wb_reg_write   <= r_mem_reg_write;
      r_wb_mem_to_reg  <= r_mem_mem_to_reg;
      r_wb_link        <= r_mem_link;
      r_wb_rd          <= r_mem_rd;
    end
  end

  assign ex_branch      = r_ex.branch;
  assign ex_jump        = r_ex.jump;
  assign ex_jalr        = r_ex.jalr;
  assign ex_mem_read    = r_ex.mem_read;
  assign ex_mem_write   = r_ex.mem_write;
  assign ex_mem_to_reg  = r_ex.mem_to_reg;
  assign ex_alu_src     = r_ex.alu_src;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_alu_op      = ALUOP_W'(r_ex.alu_op);
  assign ex_rd          = r_ex_rd;
  assign ex_illegal     = r_ex_illegal;
  assign mem_mem_read   = r_mem_mem_read;
  assign mem_mem_write  = r_mem_mem_write;
  assign mem_mem_to_reg = r_mem_mem_to_reg;
  assign mem_reg_write  = r_mem_reg_write;
  assign mem_link       = r_mem_link;
  assign mem_rd         = r_mem_rd;
  assign wb_reg_write   = r_wb_reg_write;
  assign wb_mem_to_reg  = r_wb_mem_to_reg;
  assign wb_link        = r_wb_link;
  assign wb_rd          = r_wb_rd;

endmodule

// File: tb/tb_rv32_pipe_ctrl.sv
// Bench for rv32_pipe_ctrl: vector table of hazard/flush cases plus decode sweep,
// with a stage scoreboard holding the expected ID/EX bundle history.
module tb_rv32_pipe_ctrl;

  localparam logic [4:0] B_OP = 5'b01100, B_OPIMM = 5'b00100, B_LOAD = 5'b00000;
  localparam logic [4:0] B_STORE = 5'b01000, B_BRANCH = 5'b11000, B_JAL = 5'b11011;
  localparam logic [4:0] B_JALR = 5'b11001, B_LUI = 5'b01101, B_AUIPC = 5'b00101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_inst = 32'h0;
  logic        id_valid = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        pc_write, ifid_write, ifid_flush;
  logic        ex_branch, ex_jump, ex_jalr, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_alu_src, ex_reg_write, ex_illegal;
  logic [1:0]  ex_alu_op;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_link;
  logic        wb_reg_write, wb_mem_to_reg, wb_link;

  rv32_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .ex_illegal(ex_illegal),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .mem_reg_write(mem_reg_write),
    .mem_link(mem_link), .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_link(wb_link), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       branch, jump, jalr, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
    logic [1:0] alu_op;
    logic [4:0] rd;
    logic       illegal;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic        valid;
    logic        taken;
    logic        pcw;
    logic        ifw;
    logic        fl;
  } vec_t;

  exp_t q[$];
  vec_t vt[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] mk(logic [4:0] opc, logic [4:0] rd,
                                     logic [4:0] rs1, logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b010, rd, opc, 2'b11};
  endfunction

  function automatic vec_t v(logic [31:0] inst, logic valid, logic taken,
                             logic pcw, logic ifw, logic fl);
    vec_t r;
    r.inst = inst; r.valid = valid; r.taken = taken;
    r.pcw = pcw; r.ifw = ifw; r.fl = fl;
    return r;
  endfunction

  // Reference decode written straight from the opcode table.
  function automatic exp_t ref_dec(logic [31:0] inst);
    exp_t e;
    e = '0;
    if (inst[1:0] != 2'b11) begin
      e.illegal = 1'b1;
      return e;
    end
    case (inst[6:2])
      B_OP:     begin e.reg_write = 1; e.alu_op = 2'b10; e.rd = inst[11:7]; end
      B_OPIMM:  begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'b10; e.rd = inst[11:7]; end
      B_LOAD:   begin e.mem_read = 1; e.mem_to_reg = 1; e.alu_src = 1; e.reg_write = 1;
                      e.rd = inst[11:7]; end
      B_STORE:  begin e.mem_write = 1; e.alu_src = 1; end
      B_BRANCH: begin e.branch = 1; e.alu_op = 2'b01; end
      B_JAL:    begin e.jump = 1; e.reg_write = 1; e.rd = inst[11:7]; end
      B_JALR:   begin e.jalr = 1; e.alu_src = 1; e.reg_write = 1; e.rd = inst[11:7]; end
      B_LUI:    begin e.alu_src = 1; e.reg_write = 1; e.alu_op = 2'b11; e.rd = inst[11:7]; end
      B_AUIPC:  begin e.alu_src = 1; e.reg_write = 1; e.rd = inst[11:7]; end
      default:  e.illegal = 1'b1;
    endcase
    if (inst[11:7] == 5'd0) e.reg_write = 1'b0;
    return e;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic check_stages(int idx);
    exp_t a, m, w;
    a = {ex_branch, ex_jump, ex_jalr, ex_mem_read, ex_mem_write, ex_mem_to_reg,
         ex_alu_src, ex_reg_write, ex_alu_op, ex_rd, ex_illegal};
    m = q[$-1];
    w = q[$-2];
    check("ex_bundle", idx, 32'(a), 32'(q[$]));
    check("mem_bundle", idx,
          32'({mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_link, mem_rd}),
          32'({m.mem_read, m.mem_write, m.mem_to_reg, m.reg_write, m.jump | m.jalr, m.rd}));
    check("wb_bundle", idx,
          32'({wb_reg_write, wb_mem_to_reg, wb_link, wb_rd}),
          32'({w.reg_write, w.mem_to_reg, w.jump | w.jalr, w.rd}));
  endtask

  // One ID cycle: drive, check combinational control, push expected EX bundle.
  task automatic step(int idx, logic [31:0] inst, logic valid, logic taken,
                      logic pcw, logic ifw, logic fl);
    exp_t e;
    @(negedge clk);
    rst = 1'b0; id_inst = inst; id_valid = valid; ex_branch_taken = taken;
    #1;
    check("pc_write", idx, 32'(pc_write), 32'(pcw));
    check("ifid_write", idx, 32'(ifid_write), 32'(ifw));
    check("ifid_flush", idx, 32'(ifid_flush), 32'(fl));
    e = (taken || !pcw || !valid) ? exp_t'('0) : ref_dec(inst);
    @(posedge clk); #1;
    q.push_back(e);
    while (q.size() > 3) void'(q.pop_front());
    check_stages(idx);
  endtask

  task automatic do_reset(int cycles, logic [31:0] inst, logic pcw_pre);
    @(negedge clk);
    rst = 1'b1; id_inst = inst; id_valid = 1'b1; ex_branch_taken = 1'b0;
    #1;
    check("rst_pre_pc_write", 0, 32'(pc_write), 32'(pcw_pre));
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      check("rst_stages", i,
            32'({ex_branch, ex_jump, ex_jalr, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                 ex_alu_src, ex_reg_write, ex_alu_op, ex_illegal, mem_mem_read,
                 mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_link, wb_reg_write,
                 wb_mem_to_reg, wb_link}), 32'h0);
      check("rst_rd", i, 32'({ex_rd, mem_rd, wb_rd}), 32'h0);
      check("rst_pc_write", i, 32'({pc_write, ifid_write, ifid_flush}), 32'b110);
    end
    q.delete();
    repeat (3) q.push_back('0);
  endtask

  logic [4:0] opcs [9];
  logic [4:0] rds [2];

  initial begin
    opcs = '{B_OP, B_OPIMM, B_LOAD, B_STORE, B_BRANCH, B_JAL, B_JALR, B_LUI, B_AUIPC};
    rds  = '{5'd7, 5'd0};

    // load-use on rs1, then ADD retried
    vt.push_back(v(mk(B_LOAD, 5, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_OP, 6, 5, 2),   1, 0, 0, 0, 0));
    vt.push_back(v(mk(B_OP, 6, 5, 2),   1, 0, 1, 1, 0));
    vt.push_back(v(32'h0, 0, 0, 1, 1, 0));
    vt.push_back(v(32'h0, 0, 0, 1, 1, 0));
    // x0 destination and non-using consumer
    vt.push_back(v(mk(B_LOAD, 0, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_OP, 6, 0, 2),   1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_LOAD, 5, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_LUI, 5, 5, 5),  1, 0, 1, 1, 0));
    // load-use through rs2 of a store
    vt.push_back(v(mk(B_LOAD, 7, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_STORE, 0, 2, 7), 1, 0, 0, 0, 0));
    vt.push_back(v(mk(B_STORE, 0, 2, 7), 1, 0, 1, 1, 0));
    // invalid ID slot never stalls
    vt.push_back(v(mk(B_LOAD, 8, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_OP, 9, 8, 8),   0, 0, 1, 1, 0));
    // flush wins over a pending load-use
    vt.push_back(v(mk(B_LOAD, 5, 1, 0), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_OP, 6, 5, 2),   1, 1, 1, 1, 1));
    vt.push_back(v(32'h0, 0, 0, 1, 1, 0));
    // plain flush after a branch
    vt.push_back(v(mk(B_BRANCH, 0, 1, 2), 1, 0, 1, 1, 0));
    vt.push_back(v(mk(B_JAL, 1, 0, 0),    1, 1, 1, 1, 1));
    vt.push_back(v(32'h0, 0, 0, 1, 1, 0));
    vt.push_back(v(32'h0, 0, 0, 1, 1, 0));

    do_reset(2, mk(B_LOAD, 5, 1, 0), 1'b1);
    for (int i = 0; i < vt.size(); i++)
      step(i, vt[i].inst, vt[i].valid, vt[i].taken, vt[i].pcw, vt[i].ifw, vt[i].fl);

    // decode sweep, rd=7 then rd=0
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 2; j++)
        step(100 + 2 * i + j, mk(opcs[i], rds[j], 1, 2), 1, 0, 1, 1, 0);
    repeat (3) step(200, 32'h0, 0, 0, 1, 1, 0);

    // illegal opcode and illegal low bits
    step(300, 32'h0000007F, 1, 0, 1, 1, 0);
    step(301, 32'h00000012, 1, 0, 1, 1, 0);
    repeat (3) step(302, 32'h0, 0, 0, 1, 1, 0);

    // reset arriving during a stall cycle, then the consumer proceeds
    step(400, mk(B_LOAD, 5, 1, 0), 1, 0, 1, 1, 0);
    do_reset(1, mk(B_OP, 6, 5, 2), 1'b0);
    step(401, mk(B_OP, 6, 5, 2), 1, 0, 1, 1, 0);
    repeat (3) step(402, 32'h0, 0, 0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
